// File: rtl/zle_pkg.sv
// Shared zero run-length token definitions.
// Used by the ZLE encoder and the zld_expand decoder.
package zle_pkg;

  localparam int ZLE_DW      = 3;
  localparam int ZLE_CW      = 4;
  localparam int ZLE_RUN_BIT = ZLE_CW;
  localparam int ZLE_MAX_RUN = (1 << ZLE_CW) - 1;

  typedef logic [ZLE_CW:0]   zle_tok_t;
  typedef logic [ZLE_DW-1:0] zle_sym_t;
  typedef logic [ZLE_CW-1:0] zle_cnt_t;

  function automatic zle_tok_t zle_mk_lit(
    input zle_sym_t d
  );
    zle_tok_t t;
    t = '0;
    t[ZLE_DW-1:0] = d;
    return t;
  endfunction

  function automatic zle_tok_t zle_mk_run(
    input zle_cnt_t k
  );
    return {1'b1, k};
  endfunction

  function automatic logic zle_is_run(
    input zle_tok_t t
  );
    return t[ZLE_RUN_BIT];
  endfunction

  function automatic zle_cnt_t zle_count(
    input zle_tok_t t
  );
    return t[ZLE_CW-1:0];
  endfunction

  function automatic zle_sym_t zle_data(
    input zle_tok_t t
  );
    return t[ZLE_DW-1:0];
  endfunction

endpackage

// File: rtl/zld_expand.sv
// Zero run-length decoder: literals pass through,
// run tokens expand into that many zero symbols.
module zld_expand
  import zle_pkg::*;
#(
  parameter int DW = ZLE_DW,
  parameter int CW = ZLE_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW:0]   i_d,
  input  logic          i_valid,
  output logic          i_ready,
  output logic [DW-1:0] o_d,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          run_active
);

  logic [DW-1:0] o_d_q, o_d_d;
  logic          o_valid_q, o_valid_d;
  logic [CW-1:0] rem_q, rem_d;

  logic          free;
  logic          in_run;
  logic          accept;
  logic          tok_run;
  logic [CW-1:0] tok_cnt;
  logic          lit_acc;
  logic          run_acc;

  assign free    = !o_valid_q || o_ready;
  assign in_run  = rem_q != '0;
  assign i_ready = reset && free && !in_run;
  assign accept  = i_valid && i_ready;
  assign tok_run = i_d[CW];
  assign tok_cnt = i_d[CW-1:0];
  assign lit_acc = accept && !tok_run;
  assign run_acc = accept && tok_run
                   && (tok_cnt != '0);

  // Next output slot and pending-zero count.
  // A zero-length run falls into the idle path.
  always_comb begin
    o_d_d     = o_d_q;
    o_valid_d = o_valid_q;
    rem_d     = rem_q;
    unique case (1'b1)
      in_run: begin
        if (free) begin
          o_d_d     = '0;
          o_valid_d = 1'b1;
          rem_d     = rem_q - 1'b1;
        end
      end
      lit_acc: begin
        o_d_d     = i_d[DW-1:0];
        o_valid_d = 1'b1;
      end
      run_acc: begin
        o_d_d     = '0;
        o_valid_d = 1'b1;
        rem_d     = tok_cnt - 1'b1;
      end
      default: begin
        o_valid_d = o_valid_q && !o_ready;
      end
    endcase
  end

  // Output register and run counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_d_q     <= '0;
      o_valid_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      o_d_q     <= o_d_d;
      o_valid_q <= o_valid_d;
      rem_q     <= rem_d;
    end
  end

  assign o_d        = o_d_q;
  assign o_valid    = o_valid_q;
  assign run_active = in_run;

endmodule

// File: tb/tb_zld_expand.sv
// Self-checking bench for zld_expand.
// Directed scenarios plus a random scoreboard run.
module tb_zld_expand;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] i_d = '0;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic [2:0] o_d;
  logic       o_valid;
  logic       o_ready = 1'b1;
  logic       run_active;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ir_low = 0;
  int ra_hi = 0;

  logic [2:0] out_log[$];
  int         out_cyc[$];
  int         tok_cyc[$];

  zld_expand #(.DW(3), .CW(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_d        (i_d),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .o_d        (o_d),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .run_active (run_active)
  );

  always #5 clock = ~clock;

  // Handshake monitor, sampled with pre-edge values.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      if (i_valid && i_ready) tok_cyc.push_back(cyc);
      if (o_valid && o_ready) begin
        out_log.push_back(o_d);
        out_cyc.push_back(cyc);
      end
      if (!i_ready) ir_low <= ir_low + 1;
      if (run_active) ra_hi <= ra_hi + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    out_log.delete();
    out_cyc.delete();
    tok_cyc.delete();
    ir_low = 0;
    ra_hi = 0;
  endtask

  task automatic send_tok(input logic [4:0] t, input bit rr);
    bit done;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clock);
      if (k == 0) begin
        i_d = t;
        i_valid = 1'b1;
      end
      if (rr) o_ready = 1'($urandom_range(0, 1));
      #1;
      if (i_ready) begin
        @(posedge clock);
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_tok timeout: tok=%h i_ready=%b required 1",
               t, i_ready);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_o_valid: got %b required 0", o_valid);
    end
    n_checks++;
    if (o_d !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_o_d: got %0d required 0", o_d);
    end
    n_checks++;
    if (run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_run_active: got %b required 0", run_active);
    end
    n_checks++;
    if (i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_i_ready: got %b required 0", i_ready);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_i_ready: got %b required 1", i_ready);
    end
  endtask

  task automatic test_literals();
    logic [2:0] exp_v[3];
    exp_v = '{3'd3, 3'd5, 3'd7};
    idle(2);
    clear_logs();
    send_tok(5'h03, 0);
    send_tok(5'h05, 0);
    send_tok(5'h07, 0);
    idle(3);
    n_checks++;
    if (out_log.size() != 3 || tok_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL lit_count: got %0d outs %0d toks required 3",
               out_log.size(), tok_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_log[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL lit_value[%0d]: got %0d required %0d",
                   i, out_log[i], exp_v[i]);
        end
        n_checks++;
        if (out_cyc[i] != tok_cyc[0] + 1 + i) begin
          n_fail++;
          $display("FAIL lit_timing[%0d]: got cycle %0d required %0d",
                   i, out_cyc[i], tok_cyc[0] + 1 + i);
        end
        n_checks++;
        if (tok_cyc[i] != tok_cyc[0] + i) begin
          n_fail++;
          $display("FAIL lit_accept[%0d]: got cycle %0d required %0d",
                   i, tok_cyc[i], tok_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_run();
    logic [2:0] exp_v[5];
    exp_v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
    idle(2);
    clear_logs();
    send_tok(5'h14, 0);
    send_tok(5'h02, 0);
    idle(3);
    n_checks++;
    if (out_log.size() != 5 || tok_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL run_count: got %0d outs %0d toks required 5/2",
               out_log.size(), tok_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (out_log[i] !== exp_v[i]
            || out_cyc[i] != tok_cyc[0] + 1 + i) begin
          n_fail++;
          $display("FAIL run_seq[%0d]: got %0d@%0d required %0d@%0d",
                   i, out_log[i], out_cyc[i], exp_v[i],
                   tok_cyc[0] + 1 + i);
        end
      end
    end
    n_checks++;
    if (ir_low != 3) begin
      n_fail++;
      $display("FAIL run_i_ready_low: got %0d cycles required 3", ir_low);
    end
    n_checks++;
    if (ra_hi != 3) begin
      n_fail++;
      $display("FAIL run_active_high: got %0d cycles required 3", ra_hi);
    end
  endtask

  task automatic test_edge_runs();
    int zeros;
    idle(2);
    clear_logs();
    send_tok(5'h1F, 0);
    idle(20);
    zeros = 0;
    foreach (out_log[i]) if (out_log[i] === 3'd0) zeros++;
    n_checks++;
    if (out_log.size() != 15 || zeros != 15) begin
      n_fail++;
      $display("FAIL run15: got %0d outs %0d zeros required 15",
               out_log.size(), zeros);
    end
    clear_logs();
    send_tok(5'h10, 0);
    send_tok(5'h06, 0);
    idle(3);
    n_checks++;
    if (out_log.size() != 1 || tok_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL run0_count: got %0d outs %0d toks required 1/2",
               out_log.size(), tok_cyc.size());
    end else begin
      n_checks++;
      if (out_log[0] !== 3'd6 || out_cyc[0] != tok_cyc[1] + 1) begin
        n_fail++;
        $display("FAIL run0_lit: got %0d@%0d required 6@%0d",
                 out_log[0], out_cyc[0], tok_cyc[1] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    idle(2);
    clear_logs();
    send_tok(5'h13, 0);
    @(negedge clock);
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clock);
    o_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clock);
      #1;
      n_checks++;
      if (o_valid !== 1'b1 || o_d !== 3'd0
          || dut.rem_q !== 4'd1 || run_active !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b d=%0d rem=%0d ra=%b required 1/0/1/1",
                 s, o_valid, o_d, dut.rem_q, run_active);
      end
    end
    o_ready = 1'b1;
    idle(4);
    n_checks++;
    if (out_log.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d required 3", out_log.size());
    end else begin
      n_checks++;
      if (out_log[0] !== 3'd0 || out_log[1] !== 3'd0
          || out_log[2] !== 3'd0) begin
        n_fail++;
        $display("FAIL bp_zero: got %0d %0d %0d required 0 0 0",
                 out_log[0], out_log[1], out_log[2]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int k;
    idle(2);
    clear_logs();
    send_tok(5'h1A, 0);
    @(negedge clock);
    i_valid = 1'b0;
    k = 0;
    while (out_log.size() < 2 && k < 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_d !== 3'd0
        || run_active !== 1'b0 || i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got v=%b d=%0d ra=%b ir=%b required 0",
               o_valid, o_d, run_active, i_ready);
    end
    n_checks++;
    if (out_log.size() != 2) begin
      n_fail++;
      $display("FAIL midrun_pre: got %0d zeros required 2", out_log.size());
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (i_ready !== 1'b1 || run_active !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_release: got ir=%b ra=%b required 1/0",
               i_ready, run_active);
    end
    clear_logs();
    send_tok(5'h01, 0);
    idle(12);
    n_checks++;
    if (out_log.size() != 1 || out_log[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL midrun_after: got %0d outs first=%0d required 1 out of 1",
               out_log.size(), out_log.size() > 0 ? out_log[0] : 3'd0);
    end
  endtask

  task automatic test_random();
    logic [4:0] toks[$];
    logic [2:0] exp_q[$];
    logic [4:0] t;
    idle(2);
    clear_logs();
    for (int i = 0; i < 80; i++) begin
      t = 5'($urandom_range(0, 31));
      toks.push_back(t);
      if (t[4]) begin
        for (int z = 0; z < int'(t[3:0]); z++) exp_q.push_back(3'd0);
      end else begin
        exp_q.push_back(t[2:0]);
      end
    end
    foreach (toks[i]) send_tok(toks[i], 1);
    idle(40);
    n_checks++;
    if (tok_cyc.size() != toks.size()) begin
      n_fail++;
      $display("FAIL rand_tokens: got %0d accepted required %0d",
               tok_cyc.size(), toks.size());
    end
    n_checks++;
    if (out_log.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_len: got %0d symbols required %0d",
               out_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (out_log[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_sym[%0d]: got %0d required %0d",
                   i, out_log[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_run();
    test_edge_runs();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zld_expand.md
# zld_expand

Zero run-length decoder: the stage directly downstream of the ZLE encoder, consuming its token stream and re-expanding it to the original symbol stream. Literal tokens pass through unchanged. Run tokens expand into the encoded number of zero symbols. Both sides use valid/ready streams with a registered output, and the block sustains one output symbol per cycle.

## Interface
Parameters:
- `DW`, 3, symbol data width; matches the encoder input width.
- `CW`, 4, run-count width; the maximum run is 2^CW-1 = 15.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_d`  in  CW+1  token. Bit CW=1 marks a run token with count in [CW-1:0]. Bit CW=0 marks a literal with data in [DW-1:0]; other bits are ignored.
- `i_valid`  in  1  token present.
- `i_ready`  out  1  token accepted on a cycle where `i_valid && i_ready`.
- `o_d`  out  DW  decoded symbol.
- `o_valid`  out  1  symbol present.
- `o_ready`  in  1  downstream accepts on `o_valid && o_ready`.
- `run_active`  out  1  high while a run expansion is pending (`rem != 0`).

## Operation
- Registers: `o_d`, `o_valid`, `rem` (CW bits, zeros still to emit).
- States:
  - PASS when `rem==0`.
  - RUN when `rem!=0`.
  - The state is derived from `rem`; there is no separate state register.
- `free = !o_valid || o_ready`, meaning the output slot can be loaded this cycle.
- In PASS:
  - `i_ready = free`.
  - On accept of a literal: `o_d <= i_d[DW-1:0]`, `o_valid <= 1`.
  - On accept of a run with k≥1: `o_d <= 0`, `o_valid <= 1`, `rem <= k-1`.
  - On accept of a run with k=0: the token is consumed and nothing is emitted. `o_valid <= 0` if the slot was emptied this cycle.
  - With no accept: `o_valid <= o_valid && !o_ready`.
- In RUN:
  - `i_ready = 0`.
  - If `free`: `o_d <= 0`, `o_valid <= 1`, `rem <= rem-1`.
  - Otherwise hold all registers.
- `o_d` and `o_valid` are stable while `o_valid && !o_ready`.
- No EOS handling. Tokens are assumed legal: a literal of value 0 is passed through as-is.
- Count arithmetic is unsigned, CW bits. `rem` never underflows because it is only decremented when nonzero.

## Timing
- Reset (asserted low, asynchronous): `o_valid=0`, `o_d=0`, `rem=0`, `run_active=0`. `i_ready` is forced 0 while reset is asserted.
- Reset mid-run discards the pending zeros and any held output. The first cycle after release is PASS with `i_ready=1`.
- Literal latency is 1 cycle: a token accepted at edge N is visible at `o_d` after N.
- A run of k is accepted at edge N and produces zeros after edges N, N+1, …, N+k-1 (with `o_ready` held high).
- During a run, `i_ready` is low for k-1 cycles. The next token is accepted on the cycle the last zero is loaded out.
- Sustained throughput is 1 symbol/cycle with no bubbles between consecutive runs or literals.
- Back-pressure (`o_ready=0`) freezes `rem` and the output.
- `i_ready` is combinational from `o_valid`, `o_ready` and `rem`. There is no combinational path from `i_valid` to `i_ready`.

## Structure
- Shared package `zle_pkg` holds:
  - `DW`/`CW` defaults.
  - The token flag bit position (`ZLE_RUN_BIT = CW`).
  - The max-run constant (15).
  - Helpers to build and split tokens, shared with the encoder.
- Single flat module; no sub-module is warranted. The output register and `rem` counter live in one always block.

## Test plan
- **Literals:** tokens 0x03, 0x05, 0x07 on back-to-back cycles with `o_ready=1` -> `o_d` = 3, 5, 7 on consecutive cycles, 1-cycle latency, `i_ready` constantly 1.
- **Run:** token 0x14 (run of 4) then literal 0x02 -> `o_d` = 0,0,0,0,2 on five consecutive cycles. `i_ready` is low for exactly 3 cycles and `run_active` is high for 3 cycles.
- **Edge runs:**
  - Run 0x1F (15) -> exactly 15 zeros.
  - Run 0x10 (0) followed by literal 0x06 -> only a 6 is emitted, one cycle after the literal is accepted.
- **Back-pressure:** `o_ready` toggles 1,0,0,1 during run 0x13 -> exactly 3 zeros are delivered. `o_d`/`o_valid` stay stable while stalled, and `rem` does not decrement on stall cycles.
- **Reset:** assert `reset` after 2 of 10 zeros of run 0x1A -> outputs go to 0 immediately. After release, a fresh literal 0x01 emerges with no residual zeros.
- **Random:** random literal/run tokens with random `o_ready`, checked against a scoreboard expansion model -> output symbol sequence matches exactly, with no lost or duplicated tokens.
